// File: rtl/button_conditioner.sv
// button_conditioner
// Conditions raw push-button pins before they are used as event triggers. Each channel gets a
// 2-FF synchroniser and a counter-based debouncer. A small FSM then produces one-cycle
// press/release pulses and, on enabled channels, hold-to-auto-repeat press ticks.
//
// Ports
//   clk          system clock
//   reset_n      synchronous active-low reset
//   btn_raw      asynchronous raw button pins, active-high
//   btn_level    debounced button level
//   btn_press    1-cycle pulse on accepted press or auto-repeat tick
//   btn_release  1-cycle pulse on accepted release
//   btn_held     high while the channel is auto-repeating
module button_conditioner #(
  parameter int unsigned       N_BTN           = 2,
  parameter int unsigned       DEBOUNCE_CYCLES = 50000,
  parameter int unsigned       REPEAT_DELAY    = 5000000,
  parameter int unsigned       REPEAT_PERIOD   = 2000000,
  parameter logic [N_BTN-1:0]  REPEAT_EN       = 2'b10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_held
);

  localparam int unsigned DW   = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned HMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned HW   = (HMAX > 2) ? $clog2(HMAX) : 1;

  localparam logic [DW-1:0] DLAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] RDLAST = HW'(REPEAT_DELAY - 1);
  localparam logic [HW-1:0] RPLAST = HW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {StIdle, StHold, StRepeat} state_e;

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    logic          r_s1, r_s2, r_level, r_press, r_release;
    logic [DW-1:0] r_dcnt;
    logic [HW-1:0] r_hcnt, w_hcnt_d;
    state_e        r_state, w_state_d;
    logic          w_diff, w_accept, w_rise, w_fall, w_press_d, w_release_d;

    assign w_diff   = (r_s2 != r_level);
    // A level change is accepted on the last of DEBOUNCE_CYCLES consecutive differing samples.
    assign w_accept = w_diff && (r_dcnt == DLAST);
    assign w_rise   = w_accept && r_s2;
    assign w_fall   = w_accept && !r_s2;

    always_ff @(posedge clk) begin
      if (!reset_n) begin
        r_s1      <= 1'b0;
        r_s2      <= 1'b0;
        r_level   <= 1'b0;
        r_dcnt    <= '0;
        r_hcnt    <= '0;
        r_press   <= 1'b0;
        r_release <= 1'b0;
        r_state   <= StIdle;
      end else begin
        r_s1 <= btn_raw[i];
        r_s2 <= r_s1;
        if (!w_diff || w_accept) begin
          r_dcnt <= '0;
        end else begin
          r_dcnt <= r_dcnt + 1'b1;
        end
        if (w_accept) begin
          r_level <= r_s2;
        end
        r_state   <= w_state_d;
        r_hcnt    <= w_hcnt_d;
        r_press   <= w_press_d;
        r_release <= w_release_d;
      end
    end

    always_comb begin
      w_state_d   = r_state;
      w_hcnt_d    = r_hcnt;
      w_press_d   = 1'b0;
      w_release_d = 1'b0;
      case (r_state)
        StIdle: begin
          if (w_rise) begin
            w_press_d = 1'b1;
            w_hcnt_d  = '0;
            w_state_d = StHold;
          end
        end
        StHold: begin
          if (w_fall) begin
            w_release_d = 1'b1;
            w_state_d   = StIdle;
          end else if (r_hcnt == RDLAST) begin
            // Without repeat enabled the counter simply parks at its terminal value.
            if (REPEAT_EN[i]) begin
              w_press_d = 1'b1;
              w_hcnt_d  = '0;
              w_state_d = StRepeat;
            end
          end else begin
            w_hcnt_d = r_hcnt + 1'b1;
          end
        end
        StRepeat: begin
          // A fall landing on a repeat tick suppresses the tick.
          if (w_fall) begin
            w_release_d = 1'b1;
            w_state_d   = StIdle;
          end else if (r_hcnt == RPLAST) begin
            w_press_d = 1'b1;
            w_hcnt_d  = '0;
          end else begin
            w_hcnt_d = r_hcnt + 1'b1;
          end
        end
        default: w_state_d = StIdle;
      endcase
    end

    assign btn_level[i]   = r_level;
    assign btn_press[i]   = r_press;
    assign btn_release[i] = r_release;
    assign btn_held[i]    = (r_state == StRepeat);
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Testbench for button_conditioner with short debounce/repeat timings.
module tb_button_conditioner;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] btn_raw = 2'b00;
  logic [1:0] btn_level, btn_press, btn_release, btn_held;

  button_conditioner #(
    .N_BTN          (2),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (16),
    .REPEAT_PERIOD  (8),
    .REPEAT_EN      (2'b10)
  ) u_dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_held   (btn_held)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic       rst_n;
    logic [1:0] raw;
    logic [1:0] lvl;
    logic [1:0] prs;
    logic [1:0] rel;
    logic [1:0] hld;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [1:0] raw, input logic [1:0] lvl,
                     input logic [1:0] prs, input logic [1:0] rel, input logic [1:0] hld,
                     input int unsigned rep);
    vec_t v;
    v.rst_n = r;
    v.raw   = raw;
    v.lvl   = lvl;
    v.prs   = prs;
    v.rel   = rel;
    v.hld   = hld;
    for (int k = 0; k < int'(rep); k++) vecs.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Compares {level, press, release, held}.
  task automatic check(input string name, input logic [7:0] exp);
    logic [7:0] act;
    act = {btn_level, btn_press, btn_release, btn_held};
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got lvl/prs/rel/hld=%b, required %b", name, act, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic bpat [8];
    logic [1:0] ep, eh;
    int np, nr;

    // Reset with both pins high, then both accepted together, then both released.
    add(1'b0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 3);
    add(1'b1, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 5);
    add(1'b1, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00, 1);
    add(1'b1, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 1);
    add(1'b1, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 5);
    add(1'b1, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 1);
    add(1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2);
    // Clean ch0 press held past the repeat delay: ch0 never repeats.
    add(1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 5);
    add(1'b1, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 1);
    add(1'b1, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 24);
    add(1'b1, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 5);
    add(1'b1, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 1);
    add(1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2);

    foreach (vecs[i]) begin
      reset_n = vecs[i].rst_n;
      btn_raw = vecs[i].raw;
      step();
      check($sformatf("vec%0d", i), {vecs[i].lvl, vecs[i].prs, vecs[i].rel, vecs[i].hld});
    end

    // Bounce on ch1: short pulses are ignored, the final rise is accepted once.
    bpat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    np = 0;
    nr = 0;
    for (int k = 0; k < 8; k++) begin
      btn_raw = {bpat[k], 1'b0};
      step();
      if (btn_press[1] || btn_level[1]) np++;
      if (btn_release[1]) nr++;
    end
    n_checks++;
    if (np != 0) begin
      n_fail++;
      $display("FAIL bounce_glitch_press: got %0d press/level cycles, required 0", np);
    end
    btn_raw = 2'b10;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (btn_release[1]) nr++;
      check($sformatf("bounce_k%0d", k), (k == 6) ? 8'b10_10_00_00 : 8'b00_00_00_00);
    end

    // Auto-repeat on ch1, relative to the first press T.
    for (int k = 1; k <= 42; k++) begin
      step();
      if (btn_release[1]) nr++;
      ep = (k == 16 || k == 24 || k == 32 || k == 40) ? 2'b10 : 2'b00;
      eh = (k >= 16) ? 2'b10 : 2'b00;
      check($sformatf("repeat_T+%0d", k), {2'b10, ep, 2'b00, eh});
    end
    n_checks++;
    if (nr != 0) begin
      n_fail++;
      $display("FAIL bounce_repeat_release: got %0d release pulses, required 0", nr);
    end

    // Release so the accepted fall coincides with the T+48 repeat tick.
    btn_raw = 2'b00;
    for (int k = 43; k <= 48; k++) begin
      step();
      check($sformatf("collision_T+%0d", k), (k == 48) ? 8'b00_00_10_00 : 8'b10_00_00_10);
    end
    step();
    check("collision_after", 8'b00_00_00_00);

    // Reset while ch1 is repeating: silent abort, then a fresh press.
    btn_raw = 2'b10;
    for (int k = 1; k <= 6; k++) step();
    check("midhold_press", 8'b10_10_00_00);
    for (int k = 1; k <= 16; k++) step();
    check("midhold_first_repeat", 8'b10_10_00_10);
    step();
    step();
    reset_n = 1'b0;
    step();
    check("midhold_reset_1", 8'b00_00_00_00);
    step();
    check("midhold_reset_2", 8'b00_00_00_00);
    reset_n = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      check($sformatf("midhold_repress_k%0d", k), (k == 6) ? 8'b10_10_00_00 : 8'b00_00_00_00);
    end
    step();
    check("midhold_repress_after", 8'b10_00_00_00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
